// File: rtl/clk_rst_seq_pkg.sv
// Shared types and limits for the clock/reset sequencer.
package clk_rst_seq_pkg;

  typedef enum logic [2:0] {
    MMCM_RST,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN
  } seq_state_t;

  localparam logic [7:0] LOCK_LOSS_MAX = 8'd255;
  localparam logic [3:0] RETRY_MAX     = 4'd15;

endpackage

// File: rtl/cdc_sync_bit.sv
// Two-flop single-bit synchronizer for slow asynchronous level signals.
module cdc_sync_bit (
  input  logic clk,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic meta;
  (* ASYNC_REG = "TRUE" *) logic sync;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk) begin
    meta <= d;
    sync <= meta;
  end

  assign q = sync;

endmodule

// File: rtl/clk_rst_seq.sv
// MMCM reset driver, lock monitor and ordered domain-reset release.
module clk_rst_seq
  import clk_rst_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int STAGE_GAP_CYC    = 16,
  parameter int NUM_STAGES       = 4,
  parameter int LOCK_TIMEOUT_CYC = 1048576,
  parameter int MMCM_RST_CYC     = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  locked_i,
  output logic                  mmcm_rst_o,
  output logic [NUM_STAGES-1:0] rst_o,
  output logic                  ready_o,
  output logic [7:0]            lock_loss_cnt_o,
  output logic [3:0]            retry_cnt_o
);

  localparam int MW = $clog2(MMCM_RST_CYC + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYC + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYC + 1);
  localparam int GW = $clog2(STAGE_GAP_CYC + 1);

  // The edge entering a state already counts as that state's first cycle,
  // so pulse/timeout/gap terminate one short of their parameter; the stable
  // counter starts at 1 and therefore compares against the full value.
  localparam logic [MW-1:0] MMCM_LAST   = MW'(MMCM_RST_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYC);
  localparam logic [GW-1:0] GAP_LAST    = GW'(STAGE_GAP_CYC - 1);

  logic                  locked_s;
  seq_state_t            state, state_nxt;
  logic [MW-1:0]         mmcm_cnt, mmcm_cnt_nxt;
  logic [TW-1:0]         tmo_cnt, tmo_cnt_nxt;
  logic [SW-1:0]         stable_cnt, stable_cnt_nxt;
  logic [GW-1:0]         gap_cnt, gap_cnt_nxt;
  logic                  mmcm_rst_nxt;
  logic [NUM_STAGES-1:0] rst_nxt;
  logic                  ready_nxt;
  logic [7:0]            lock_loss_nxt;
  logic [3:0]            retry_nxt;

  cdc_sync_bit u_lock_sync (
    .clk (sys_clk),
    .d   (locked_i),
    .q   (locked_s)
  );

  // State, counters and all outputs are registered here.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state           <= MMCM_RST;
      mmcm_cnt        <= '0;
      tmo_cnt         <= '0;
      stable_cnt      <= '0;
      gap_cnt         <= '0;
      mmcm_rst_o      <= 1'b1;
      rst_o           <= '1;
      ready_o         <= 1'b0;
      lock_loss_cnt_o <= '0;
      retry_cnt_o     <= '0;
    end else begin
      state           <= state_nxt;
      mmcm_cnt        <= mmcm_cnt_nxt;
      tmo_cnt         <= tmo_cnt_nxt;
      stable_cnt      <= stable_cnt_nxt;
      gap_cnt         <= gap_cnt_nxt;
      mmcm_rst_o      <= mmcm_rst_nxt;
      rst_o           <= rst_nxt;
      ready_o         <= ready_nxt;
      lock_loss_cnt_o <= lock_loss_nxt;
      retry_cnt_o     <= retry_nxt;
    end
  end

  // Next-state and next-output logic; a lock drop always wins over a count.
  always_comb begin
    state_nxt      = state;
    mmcm_cnt_nxt   = mmcm_cnt;
    tmo_cnt_nxt    = tmo_cnt;
    stable_cnt_nxt = stable_cnt;
    gap_cnt_nxt    = gap_cnt;
    mmcm_rst_nxt   = mmcm_rst_o;
    rst_nxt        = rst_o;
    ready_nxt      = ready_o;
    lock_loss_nxt  = lock_loss_cnt_o;
    retry_nxt      = retry_cnt_o;

    case (state)
      MMCM_RST: begin
        if (mmcm_cnt == MMCM_LAST) begin
          state_nxt    = WAIT_LOCK;
          mmcm_rst_nxt = 1'b0;
          tmo_cnt_nxt  = '0;
        end else begin
          mmcm_cnt_nxt = mmcm_cnt + MW'(1);
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt      = STABLE;
          stable_cnt_nxt = SW'(1);
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt    = MMCM_RST;
          mmcm_rst_nxt = 1'b1;
          mmcm_cnt_nxt = '0;
          if (retry_cnt_o != RETRY_MAX) retry_nxt = retry_cnt_o + 4'd1;
        end else begin
          tmo_cnt_nxt = tmo_cnt + TW'(1);
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_nxt   = WAIT_LOCK;
          tmo_cnt_nxt = '0;
        end else if (stable_cnt == STABLE_LAST) begin
          state_nxt   = RELEASE;
          gap_cnt_nxt = '0;
        end else begin
          stable_cnt_nxt = stable_cnt + SW'(1);
        end
      end
      RELEASE, RUN: begin
        if (!locked_s) begin
          state_nxt   = WAIT_LOCK;
          tmo_cnt_nxt = '0;
          rst_nxt     = '1;
          ready_nxt   = 1'b0;
          if (lock_loss_cnt_o != LOCK_LOSS_MAX) lock_loss_nxt = lock_loss_cnt_o + 8'd1;
        end else if (state == RELEASE) begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt_nxt = '0;
            // Shifting a zero in from bit 0 releases stages strictly in ascending order.
            rst_nxt = rst_o << 1;
            if (rst_nxt == '0) begin
              state_nxt = RUN;
              ready_nxt = 1'b1;
            end
          end else begin
            gap_cnt_nxt = gap_cnt + GW'(1);
          end
        end
      end
      default: begin
        state_nxt    = MMCM_RST;
        mmcm_rst_nxt = 1'b1;
        mmcm_cnt_nxt = '0;
        rst_nxt      = '1;
        ready_nxt    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_clk_rst_seq.sv
// Self-checking bench for clk_rst_seq using an edge-timestamp reference model.
module tb_clk_rst_seq;

  localparam int L   = 8;
  localparam int G   = 4;
  localparam int N   = 3;
  localparam int TMO = 64;
  localparam int M   = 4;

  localparam int P_PULSE = 0;
  localparam int P_WAIT  = 1;
  localparam int P_LOCK  = 2;

  logic         sys_clk = 1'b0;
  logic         sys_rst;
  logic         locked_i;
  logic         mmcm_rst_o;
  logic [N-1:0] rst_o;
  logic         ready_o;
  logic [7:0]   lock_loss_cnt_o;
  logic [3:0]   retry_cnt_o;

  int    checks = 0;
  int    failures = 0;
  int    n = 0;
  int    base = 0;
  int    mphase, mr, mw, mt, mloss, mretry;
  logic  li_d1, li_d2;
  string tag;

  clk_rst_seq #(
    .LOCK_STABLE_CYC  (L),
    .STAGE_GAP_CYC    (G),
    .NUM_STAGES       (N),
    .LOCK_TIMEOUT_CYC (TMO),
    .MMCM_RST_CYC     (M)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst         (sys_rst),
    .locked_i        (locked_i),
    .mmcm_rst_o      (mmcm_rst_o),
    .rst_o           (rst_o),
    .ready_o         (ready_o),
    .lock_loss_cnt_o (lock_loss_cnt_o),
    .retry_cnt_o     (retry_cnt_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s/%s edge=%0d got=%0h exp=%0h", tag, name, n - base, got, exp);
    end
  endtask

  // Reference: the pulse starts at edge mr, waiting starts at mw, lock seen at mt.
  // Release times follow directly from mt; lock seen by the design lags locked_i by 2 edges.
  task automatic model_update();
    logic ls;
    ls    = li_d2;
    li_d2 = li_d1;
    li_d1 = locked_i;
    if (sys_rst) begin
      mphase = P_PULSE; mr = n; mloss = 0; mretry = 0;
    end else begin
      case (mphase)
        P_PULSE: if (n == mr + M) begin mphase = P_WAIT; mw = n; end
        P_WAIT: begin
          if (ls === 1'b1) begin
            mphase = P_LOCK; mt = n;
          end else if (n == mw + TMO) begin
            mphase = P_PULSE; mr = n;
            if (mretry < 15) mretry++;
          end
        end
        default: begin
          if (ls !== 1'b1) begin
            if (n > mt + L && mloss < 255) mloss++;
            mphase = P_WAIT; mw = n;
          end
        end
      endcase
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] er;
    logic         erdy;
    for (int k = 0; k < N; k++) er[k] = !(mphase == P_LOCK && n >= mt + L + (k + 1) * G);
    erdy = (mphase == P_LOCK) && (n >= mt + L + N * G);
    chk("mmcm_rst_o", 32'(mmcm_rst_o), 32'(mphase == P_PULSE));
    chk("rst_o", 32'(rst_o), 32'(er));
    chk("ready_o", 32'(ready_o), 32'(erdy));
    chk("lock_loss_cnt_o", 32'(lock_loss_cnt_o), 32'(mloss));
    chk("retry_cnt_o", 32'(retry_cnt_o), 32'(mretry));
  endtask

  task automatic step(input logic li, input logic sr);
    @(negedge sys_clk);
    locked_i = li;
    sys_rst  = sr;
    @(posedge sys_clk);
    #1;
    n++;
    model_update();
    check_outputs();
  endtask

  task automatic run_to(input int target, input logic li);
    while (n < target) step(li, 1'b0);
  endtask

  initial begin
    sys_rst = 1'b1; locked_i = 1'b0; li_d1 = 1'b0; li_d2 = 1'b0;
    mphase = P_PULSE; mr = 0; mw = 0; mt = 0; mloss = 0; mretry = 0;

    tag = "reset";
    repeat (3) step(1'b0, 1'b1);
    base = n;
    chk("mmcm", 32'(mmcm_rst_o), 1);
    chk("rst", 32'(rst_o), 'b111);
    chk("ready", 32'(ready_o), 0);

    tag = "nominal";
    run_to(base + 3, 1'b0);  chk("mmcm_hi", 32'(mmcm_rst_o), 1);
    step(1'b0, 1'b0);        chk("mmcm_lo", 32'(mmcm_rst_o), 0);
    run_to(base + 19, 1'b0);
    run_to(base + 33, 1'b1); chk("rst_e33", 32'(rst_o), 'b111);
    step(1'b1, 1'b0);        chk("rst_e34", 32'(rst_o), 'b110);
    run_to(base + 37, 1'b1); chk("rst_e37", 32'(rst_o), 'b110);
    step(1'b1, 1'b0);        chk("rst_e38", 32'(rst_o), 'b100);
    run_to(base + 41, 1'b1); chk("rst_e41", 32'(rst_o), 'b100);
                             chk("ready_e41", 32'(ready_o), 0);
    step(1'b1, 1'b0);        chk("rst_e42", 32'(rst_o), 'b000);
                             chk("ready_e42", 32'(ready_o), 1);
    run_to(base + 50, 1'b1);

    tag = "lock_loss";
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);        chk("rst_e52", 32'(rst_o), 'b000);
    step(1'b0, 1'b0);        chk("rst_e53", 32'(rst_o), 'b111);
                             chk("ready_e53", 32'(ready_o), 0);
                             chk("loss_e53", 32'(lock_loss_cnt_o), 1);
    run_to(base + 60, 1'b0);
    run_to(base + 74, 1'b1); chk("rst_e74", 32'(rst_o), 'b111);
    step(1'b1, 1'b0);        chk("rst_e75", 32'(rst_o), 'b110);
    run_to(base + 82, 1'b1); chk("ready_e82", 32'(ready_o), 0);
    step(1'b1, 1'b0);        chk("ready_e83", 32'(ready_o), 1);

    tag = "timeout";
    run_to(base + 89, 1'b1);
    run_to(base + 155, 1'b0); chk("mmcm_e155", 32'(mmcm_rst_o), 0);
                              chk("loss_e155", 32'(lock_loss_cnt_o), 2);
    step(1'b0, 1'b0);         chk("mmcm_e156", 32'(mmcm_rst_o), 1);
                              chk("retry_e156", 32'(retry_cnt_o), 1);
    run_to(base + 159, 1'b0); chk("mmcm_e159", 32'(mmcm_rst_o), 1);
    step(1'b0, 1'b0);         chk("mmcm_e160", 32'(mmcm_rst_o), 0);
    run_to(base + 223, 1'b0); chk("mmcm_e223", 32'(mmcm_rst_o), 0);
    step(1'b0, 1'b0);         chk("mmcm_e224", 32'(mmcm_rst_o), 1);
                              chk("retry_e224", 32'(retry_cnt_o), 2);
    run_to(base + 156 + 68 * 16 + 1, 1'b0);
    chk("retry_sat", 32'(retry_cnt_o), 15);

    tag = "reset_mid_release";
    for (int i = 0; i < 400 && !(mphase == P_LOCK && n == mt + L + G + 1); i++) step(1'b1, 1'b0);
    chk("rst_released0", 32'(rst_o), 'b110);
    step(1'b1, 1'b1);
    base = n;
    chk("rst", 32'(rst_o), 'b111);
    chk("mmcm", 32'(mmcm_rst_o), 1);
    chk("ready", 32'(ready_o), 0);
    chk("loss", 32'(lock_loss_cnt_o), 0);
    chk("retry", 32'(retry_cnt_o), 0);

    tag = "glitch";
    run_to(base + 7, 1'b1);
    run_to(base + 10, 1'b0);
    run_to(base + 12, 1'b1); chk("rst_e12", 32'(rst_o), 'b111);
    run_to(base + 24, 1'b1); chk("rst_e24", 32'(rst_o), 'b111);
                             chk("loss_e24", 32'(lock_loss_cnt_o), 0);
    step(1'b1, 1'b0);        chk("rst_e25", 32'(rst_o), 'b110);

    tag = "saturation";
    for (int e = 0; e < 300; e++) begin
      int extra;
      extra = $urandom_range(0, N * G + 4);
      for (int i = 0; i < 200 && !(mphase == P_LOCK && n >= mt + L + extra); i++) step(1'b1, 1'b0);
      repeat ($urandom_range(1, 4)) step(1'b0, 1'b0);
      repeat (2) step(1'b1, 1'b0);
    end
    repeat (4) step(1'b1, 1'b0);
    chk("loss_sat", 32'(lock_loss_cnt_o), 255);

    tag = "soak";
    for (int s = 0; s < 60; s++) begin
      logic li;
      int   len;
      li  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 90);
      if ($urandom_range(0, 19) == 0) step(li, 1'b1);
      repeat (len) step(li, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_rst_seq.md
# clk_rst_seq

- Reset sequencer and lock monitor placed directly downstream of the clock-wizard (MMCM) wrapper.
- Drives the MMCM reset and watches its asynchronous `locked` output.
- Releases a set of active-high domain resets in fixed order once lock is stable.
- Re-arms on lock loss, retries the MMCM on lock timeout, and keeps saturating event counters for debug.

## Interface
Parameters:
- `LOCK_STABLE_CYC`, 1024: consecutive cycles `locked` must stay high before any reset is released.
- `STAGE_GAP_CYC`, 16: cycles between successive stage releases. Must be ≥1.
- `NUM_STAGES`, 4: number of sequenced reset outputs, 1..8.
- `LOCK_TIMEOUT_CYC`, 1048576: cycles without lock before an MMCM retry.
- `MMCM_RST_CYC`, 8: width of the MMCM reset pulse.

Ports:
- `sys_clk`, in, 1: the single clock. Free-running board clock, never an MMCM output.
- `sys_rst`, in, 1: synchronous, active-high reset.
- `locked_i`, in, 1: MMCM lock. Asynchronous; synchronized internally.
- `mmcm_rst_o`, out, 1: active-high reset to the clock wizard.
- `rst_o`, out, `NUM_STAGES`: active-high domain resets. Bit 0 is released first.
- `ready_o`, out, 1: high while all stages are released and lock is held.
- `lock_loss_cnt_o`, out, 8: lock drops seen in RELEASE/RUN. Saturates at 255.
- `retry_cnt_o`, out, 4: lock timeouts. Saturates at 15.

## Operation
- `locked_i` passes through a 2-FF synchronizer to form `locked_s`, adding 2 cycles of latency.
- All outputs are registered.
- Values while `sys_rst` is high, and on the first edge after: `mmcm_rst_o`=1, `rst_o`=all 1, `ready_o`=0, both counters 0, state MMCM_RST.
- States:
  - MMCM_RST: `mmcm_rst_o`=1 for exactly `MMCM_RST_CYC` cycles, then go to WAIT_LOCK with `mmcm_rst_o`=0.
  - WAIT_LOCK:
    - `locked_s`=1: go to STABLE, stable counter = 1.
    - `LOCK_TIMEOUT_CYC` cycles elapse without lock: increment `retry_cnt_o` (saturating) and go to MMCM_RST.
  - STABLE:
    - Counts cycles with `locked_s`=1. When the count reaches `LOCK_STABLE_CYC`, go to RELEASE with the gap counter cleared.
    - `locked_s`=0: go to WAIT_LOCK and clear the timeout counter. This is not counted as a lock loss.
  - RELEASE:
    - Each time the gap counter reaches `STAGE_GAP_CYC`, clear the next `rst_o[k]`.
    - After `rst_o[NUM_STAGES-1]` is cleared, go to RUN. `ready_o` rises on the same edge as that last release.
  - RUN: hold; `ready_o`=1.
- Lock loss in RELEASE or RUN (`locked_s`=0):
  - On the next edge, set all `rst_o`=1 and `ready_o`=0.
  - Increment `lock_loss_cnt_o` (saturating).
  - Go to WAIT_LOCK.
  - `mmcm_rst_o` is not pulsed.
- `sys_rst` asserted in any state overrides everything, including mid-RELEASE. Counters clear.
- `rst_o` bits only ever deassert in ascending index order and reassert together.

## Timing
- Let T be the first edge at which `locked_s`=1 while in WAIT_LOCK. T is the `locked_i` rising edge + 2 edges.
- `rst_o[k]` is low from edge T + `LOCK_STABLE_CYC` + (k+1)·`STAGE_GAP_CYC`.
- `ready_o` is high from edge T + `LOCK_STABLE_CYC` + `NUM_STAGES`·`STAGE_GAP_CYC`.
- Lock loss: `locked_i` falls, then all `rst_o` are high 3 edges later (2 for synchronization, 1 for registering).
- A timeout re-asserts `mmcm_rst_o` on the edge after the `LOCK_TIMEOUT_CYC`-th WAIT_LOCK cycle.
- Counter widths are `$clog2(max+1)` of each parameter. No wrap-around occurs; every count compare is an exact equality.
- If a lock drop and a completing count land on the same edge, the lock drop wins.

## Structure
- Package `clk_rst_seq_pkg` holds:
  - the state enum `seq_state_t` (MMCM_RST, WAIT_LOCK, STABLE, RELEASE, RUN);
  - the counter saturation limits (255, 15).
- Sub-module `cdc_sync_bit`: 2-FF single-bit synchronizer carrying `ASYNC_REG` attributes. It is reusable by other blocks in the codebase.

## Test plan
Test parameters: `LOCK_STABLE_CYC`=8, `STAGE_GAP_CYC`=4, `NUM_STAGES`=3, `LOCK_TIMEOUT_CYC`=64, `MMCM_RST_CYC`=4.
- Nominal: release `sys_rst`, raise `locked_i` at edge 20 → T=22; `rst_o[0..2]` fall at edges 34, 38, 42; `ready_o` rises at 42; `mmcm_rst_o` high for the 4 cycles after reset.
- Glitch in STABLE: `locked_i` low for 3 cycles during STABLE → no `rst_o` change, `lock_loss_cnt_o`=0, the stable count restarts from the new T.
- Timeout: hold `locked_i`=0 → `mmcm_rst_o` re-pulses for 4 cycles every 68 cycles; `retry_cnt_o` steps 1, 2, … and sticks at 15.
- Lock loss in RUN: drop `locked_i` → all `rst_o`=1 and `ready_o`=0 after 3 edges, `lock_loss_cnt_o`=1; relock gives the same release schedule relative to the new T.
- Reset mid-RELEASE: assert `sys_rst` after `rst_o[0]` falls → all `rst_o`=1, `mmcm_rst_o`=1, counters 0 on the next edge.
- Saturation: 300 lock-loss events → `lock_loss_cnt_o` holds 255.
